distributor8way: RTL

//  8-way 4-bit distributor: the write-side counterpart of selector8way. A single 4-bit

---
 rtl/distributor8way_pkg.sv | 23 ++
 rtl/distributor8way_if.sv | 28 ++
 rtl/distributor8way_lane_buffer.sv | 41 ++++
 rtl/distributor8way.sv | 65 ++++++
 4 files changed

// File: rtl/distributor8way_pkg.sv
// Shared constants and lane naming for the 8-way distributor and its selector8way-compatible benches.
package distributor8way_pkg;

  localparam int unsigned LANES = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    LANE_A = 3'd0,
    LANE_B = 3'd1,
    LANE_C = 3'd2,
    LANE_D = 3'd3,
    LANE_E = 3'd4,
    LANE_F = 3'd5,
    LANE_G = 3'd6,
    LANE_H = 3'd7
  } lane_e;

  // Round-robin successor; the natural SEL_W-bit wrap gives 7 -> 0.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p);
    return p + SEL_W'(1);
  endfunction

endpackage

// File: rtl/distributor8way_if.sv
// Producer-side handshake plus the eight consumer lanes of the distributor.
interface distributor8way_if
  import distributor8way_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) ();

  logic [WIDTH-1:0]       in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [SEL_W-1:0]       in_sel;
  logic                   rr_mode;
  logic [LANES*WIDTH-1:0] out_data;
  logic [LANES-1:0]       out_valid;
  logic [LANES-1:0]       out_ack;
  logic [SEL_W-1:0]       rr_ptr;

  modport master (
    output in_data, in_valid, in_sel, rr_mode, out_ack,
    input  in_ready, out_data, out_valid, rr_ptr
  );

  modport slave (
    input  in_data, in_valid, in_sel, rr_mode, out_ack,
    output in_ready, out_data, out_valid, rr_ptr
  );

endinterface

// File: rtl/distributor8way_lane_buffer.sv
// One-entry lane register: load wins over ack, data is kept (not zeroed) when the lane drains.
module lane_buffer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             ack,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = din;
      valid_d = 1'b1;
    end else if (ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dout  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/distributor8way.sv
// Steers one valid/ready input stream into eight one-entry lane buffers, chosen by select or round-robin.
module distributor8way
  import distributor8way_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  distributor8way_if.slave  bus
);

  logic [SEL_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]             target;
  logic                         ready;
  logic                         xfer;
  logic [LANES-1:0]             load;
  logic [LANES-1:0]             lane_valid;
  logic [LANES-1:0][WIDTH-1:0]  lane_data;

  always_comb begin
    target = bus.rr_mode ? rr_ptr_q : bus.in_sel;
    // A full lane being acked this cycle frees its slot in time for a same-cycle refill.
    ready  = ~rst & (~lane_valid[target] | bus.out_ack[target]);
    xfer   = bus.in_valid & ready;
    load   = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      load[k] = xfer && (target == SEL_W'(k));
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer && bus.rr_mode) begin
      rr_ptr_d = next_ptr(rr_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_buffer #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (load[g]),
      .ack   (bus.out_ack[g]),
      .din   (bus.in_data),
      .dout  (lane_data[g]),
      .valid (lane_valid[g])
    );
  end

  always_comb begin
    bus.in_ready  = ready;
    bus.out_data  = lane_data;
    bus.out_valid = lane_valid;
    bus.rr_ptr    = rr_ptr_q;
  end

endmodule
